// File: rtl/lfsr_sampler.sv
// lfsr_sampler
//   Controller and consumer for an external configurable LFSR.  After reset
//   it holds the LFSR in reset for exactly NBITS cycles so the register fills,
//   waits for the LFSR's all-ones ready flag, and then steps the LFSR once
//   every DIV clocks.  The pre-shift MSB of each step is packed into an
//   SBITS-wide word.  Each word is offered on a valid/ready handshake.
//
//   Optional build macro LFSR_SAMPLER_LOCKUP_DETECT_EN: while running, an LFSR
//   value equal to LOCK_VAL sends the block back through the fill sequence.
//   It also discards the partial word and raises lockup for one cycle.
//   Without the macro, lockup is tied low.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   run          in   permits LFSR stepping while high
//   lfsr_q       in   LFSR register value (NBITS)
//   lfsr_ready   in   LFSR all-ones flag
//   lfsr_reset   out  registered reset to the LFSR
//   lfsr_enable  out  combinational step strobe to the LFSR
//   sample_data  out  packed random word (SBITS)
//   sample_valid out  sample_data holds an unconsumed word
//   sample_ready in   consumer accepts the word
//   running      out  high while in the RUN state
//   lockup       out  one-cycle lock-up pulse
module lfsr_sampler #(
  parameter int          NBITS    = 8,
  parameter int          SBITS    = 8,
  parameter int          DIV      = 1,
  parameter int unsigned LOCK_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [NBITS-1:0] lfsr_q,
  input  logic             lfsr_ready,
  output logic             lfsr_reset,
  output logic             lfsr_enable,
  output logic [SBITS-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             running,
  output logic             lockup
);

  // The init/wait counter must reach 2*NBITS-1 for the WAIT timeout.
  localparam int CW = $clog2(2 * NBITS);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (SBITS > 1) ? $clog2(SBITS) : 1;

  localparam logic [CW-1:0]    INIT_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0]    WAIT_LAST = CW'(2 * NBITS - 1);
  localparam logic [DW-1:0]    DIV_LAST  = DW'(DIV - 1);
  localparam logic [BW-1:0]    BCNT_LAST = BW'(SBITS - 1);
  localparam logic [NBITS-1:0] LOCK_Q    = NBITS'(LOCK_VAL);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_lfsr_reset;
  logic [DW-1:0]    r_div;
  logic [SBITS-1:0] r_acc;
  logic [BW-1:0]    r_bcnt;
  logic             r_acc_full;
  logic [SBITS-1:0] r_data;
  logic             r_valid;
  logic             r_running;

  logic w_init_done;
  logic w_wait_tmo;
  logic w_div_last;
  logic w_lock;
  logic w_step;
  logic w_xfer;

  assign w_init_done = (r_cnt == INIT_LAST);
  assign w_wait_tmo  = (r_cnt == WAIT_LAST);
  assign w_div_last  = (r_div == DIV_LAST);

`ifdef LFSR_SAMPLER_LOCKUP_DETECT_EN
  logic r_lockup;

  assign w_lock = (r_state == S_RUN) && (lfsr_q == LOCK_Q);

  always_ff @(posedge clk) begin
    if (reset) r_lockup <= 1'b0;
    else       r_lockup <= w_lock;
  end

  assign lockup = r_lockup;
`else
  // Only the MSB of the LFSR is consumed when detection is compiled out.
  logic w_unused_lock;
  assign w_unused_lock = ^{LOCK_Q, lfsr_q};
  assign w_lock        = 1'b0;
  assign lockup        = 1'b0;
`endif

  // A lock-up cycle neither steps the LFSR nor publishes the discarded word.
  assign w_step = (r_state == S_RUN) && run && w_div_last && !r_acc_full && !w_lock;
  assign w_xfer = r_acc_full && (!r_valid || sample_ready) && !w_lock;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (w_init_done) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (lfsr_ready)      w_state_nxt = S_RUN;
        else if (w_wait_tmo) w_state_nxt = S_INIT;
      end
      S_RUN:   if (w_lock) w_state_nxt = S_INIT;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // ---- fill / wait counter and LFSR reset ----
  // The LFSR reset is released on the edge that leaves INIT.  It is set again
  // on every re-entry to INIT, so each fill lasts exactly NBITS cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_lfsr_reset <= 1'b1;
    end else begin
      case (r_state)
        S_INIT: begin
          if (w_init_done) begin
            r_cnt        <= '0;
            r_lfsr_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (lfsr_ready) begin
            r_cnt <= '0;
          end else if (w_wait_tmo) begin
            r_cnt        <= '0;
            r_lfsr_reset <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (w_lock) begin
            r_cnt        <= '0;
            r_lfsr_reset <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // ---- step-rate divider ----
  // The divider runs up to DIV-1 and parks there until a step consumes it.
  // A full accumulator therefore stalls with div at DIV-1.  The step spacing
  // also survives word boundaries when DIV > 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_state == S_WAIT && lfsr_ready) begin
      r_div <= '0;
    end else if (w_step) begin
      r_div <= '0;
    end else if (r_state == S_RUN && run && !w_div_last) begin
      r_div <= r_div + DW'(1);
    end
  end

  // ---- bit accumulator ----
  // The pre-shift MSB enters at the LSB, so the first bit lands in the word MSB.
  always_ff @(posedge clk) begin
    if (reset || w_lock) begin
      r_acc      <= '0;
      r_bcnt     <= '0;
      r_acc_full <= 1'b0;
    end else if (w_xfer) begin
      r_bcnt     <= '0;
      r_acc_full <= 1'b0;
    end else if (w_step) begin
      r_acc <= (r_acc << 1) | SBITS'(lfsr_q[NBITS-1]);
      if (r_bcnt == BCNT_LAST) r_acc_full <= 1'b1;
      else                     r_bcnt     <= r_bcnt + BW'(1);
    end
  end

  // ---- output word register and handshake ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= r_acc;
      r_valid <= 1'b1;
    end else if (r_valid && sample_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_running <= 1'b0;
    else       r_running <= (w_state_nxt == S_RUN);
  end

  assign lfsr_reset   = r_lfsr_reset;
  assign lfsr_enable  = w_step;
  assign sample_data  = r_data;
  assign sample_valid = r_valid;
  assign running      = r_running;

endmodule

// File: tb/tb_lfsr_sampler.sv
// Bench for lfsr_sampler: two instances (DIV=1 and DIV=3).  Each drives its
// own Galois LFSR fixture (taps 8'h1D, fills with ones while held in reset).
// Delivered words are scored against a reference.  The reference builds each
// word from the MSBs of successive LFSR states, starting at 0xFF.
module tb_lfsr_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic run1, run3;
  logic sr1, sr3;
  logic force1;
  logic mon1_en;

  logic [7:0] q1 = 8'h00;
  logic [7:0] q3 = 8'h00;
  logic [7:0] lq1;
  logic       rdy1, rdy3;
  logic       lr1, en1, sv1, running1, lockup1;
  logic       lr3, en3, sv3, running3, lockup3;
  logic [3:0] sd1, sd3;

  int n_chk  = 0;
  int n_fail = 0;
  int widx1  = 0;
  int widx3  = 0;

  assign lq1  = force1 ? 8'h00 : q1;
  assign rdy1 = (q1 == 8'hFF);
  assign rdy3 = (q3 == 8'hFF);

  lfsr_sampler #(.NBITS(8), .SBITS(4), .DIV(1), .LOCK_VAL(0)) u_dut1 (
    .clk(clk), .reset(reset), .run(run1), .lfsr_q(lq1), .lfsr_ready(rdy1),
    .lfsr_reset(lr1), .lfsr_enable(en1), .sample_data(sd1),
    .sample_valid(sv1), .sample_ready(sr1), .running(running1), .lockup(lockup1)
  );

  lfsr_sampler #(.NBITS(8), .SBITS(4), .DIV(3), .LOCK_VAL(0)) u_dut3 (
    .clk(clk), .reset(reset), .run(run3), .lfsr_q(q3), .lfsr_ready(rdy3),
    .lfsr_reset(lr3), .lfsr_enable(en3), .sample_data(sd3),
    .sample_valid(sv3), .sample_ready(sr3), .running(running3), .lockup(lockup3)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  // Expected k-th word after a fill: the MSBs of LFSR states 4k..4k+3.
  function automatic logic [3:0] exp_word(input int k);
    logic [7:0] s;
    logic [3:0] w;
    s = 8'hFF;
    w = 4'h0;
    for (int i = 0; i < 4 * k; i++) s = lfsr_next(s);
    for (int b = 0; b < 4; b++) begin
      w = {w[2:0], s[7]};
      s = lfsr_next(s);
    end
    return w;
  endfunction

  // External LFSR fixtures.
  always @(posedge clk) begin
    if (lr1)      q1 <= {q1[6:0], 1'b1};
    else if (en1) q1 <= lfsr_next(q1);
    if (lr3)      q3 <= {q3[6:0], 1'b1};
    else if (en3) q3 <= lfsr_next(q3);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word scoreboards and hold-under-backpressure monitor.
  initial begin
    logic       pv, pr, prst;
    logic [3:0] pd;
    pv = 1'b0; pr = 1'b0; prst = 1'b1; pd = 4'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        widx1 = 0;
        widx3 = 0;
      end else begin
        if (mon1_en && sv1 && sr1) begin
          check_eq("word1", 32'(sd1), 32'(exp_word(widx1)));
          widx1++;
        end
        if (sv3 && sr3) begin
          check_eq("word3", 32'(sd3), 32'(exp_word(widx3)));
          widx3++;
        end
        if (!prst && pv && !pr)
          check_eq("hold1", 32'({sv1, sd1}), 32'({1'b1, pd}));
      end
      pv = sv1; pr = sr1; pd = sd1; prst = reset;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] tbl [9];
    int n, kseq, nw, last, have, any, cnt;
    logic [7:0] qsave;
    tbl = '{8'hFF, 8'hE3, 8'hDB, 8'hAB, 8'h4B, 8'h96, 8'h31, 8'h62, 8'hC4};

    reset = 1'b1; run1 = 1'b1; run3 = 1'b1; sr1 = 1'b1; sr3 = 1'b1;
    force1 = 1'b0; mon1_en = 1'b1;

    // Reset state.
    step();
    check_eq("rst_lfsr_reset", 32'(lr1), 32'd1);
    check_eq("rst_enable", 32'(en1), 32'd0);
    check_eq("rst_valid", 32'(sv1), 32'd0);
    check_eq("rst_data", 32'(sd1), 32'd0);
    check_eq("rst_running", 32'(running1), 32'd0);
    check_eq("rst_lockup", 32'(lockup1), 32'd0);
    step(); step();
    reset = 1'b0;

    // Fill timing.
    n = 0;
    while (lr1 && n < 50) begin n++; step(); end
    check_eq("fill_len", 32'(n), 32'd8);
    check_eq("wait_ready", 32'(rdy1), 32'd1);
    check_eq("wait_not_running", 32'(running1), 32'd0);
    step();
    check_eq("running_up", 32'(running1), 32'd1);

    // Step sequence, word values and valid spacing at DIV=1.
    kseq = 0; nw = 0; last = 0; have = 0;
    for (int c = 0; c < 40; c++) begin
      if (en1 && kseq < 9) begin
        check_eq("lfsr_seq", 32'(q1), 32'(tbl[kseq]));
        kseq++;
      end
      if (sv1) begin
        if (nw < 2) check_eq("first_words", 32'(sd1), (nw == 0) ? 32'hF : 32'h4);
        if (have != 0) check_eq("valid_gap", 32'(c - last), 32'd5);
        last = c; have = 1; nw++;
      end
      step();
    end
    check_eq("seq_count", 32'(kseq), 32'd9);

    // Backpressure.
    sr1 = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    n = 0;
    while (!sv1 && n < 60) begin n++; step(); end
    check_eq("bp_valid_timeout", 32'(n < 60), 32'd1);
    check_eq("bp_first", 32'(sd1), 32'hF);
    any = 0;
    for (int c = 0; c < 20; c++) begin
      if (c >= 10 && en1) any = 1;
      step();
    end
    check_eq("stall_enable", 32'(any), 32'd0);
    check_eq("stall_lfsr", 32'(q1), 32'hC4);
    check_eq("stall_data", 32'({sv1, sd1}), 32'h1F);
    sr1 = 1'b1;
    step();
    check_eq("bp_second", 32'({sv1, sd1}), 32'h14);

    // Rate (DIV=3) and run gating.
    n = 0;
    while (!running3 && n < 60) begin n++; step(); end
    check_eq("run3_timeout", 32'(n < 60), 32'd1);
    have = 0; last = 0;
    for (int c = 0; c < 30; c++) begin
      if (en3) begin
        if (have != 0) check_eq("div3_gap", 32'(c - last), 32'd3);
        last = c; have = 1;
      end
      step();
    end
    step();
    run3 = 1'b0;
    qsave = q3;
    any = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (en3) any = 1;
    end
    check_eq("run_off_enable", 32'(any), 32'd0);
    check_eq("run_off_hold", 32'(q3), 32'(qsave));
    run3 = 1'b1;
    for (int c = 0; c < 40; c++) step();

    // Reset mid-word while a word is pending.
    sr1 = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    n = 0;
    while (!sv1 && n < 60) begin n++; step(); end
    cnt = 0; n = 0;
    while (cnt < 2 && n < 20) begin
      if (en1) cnt++;
      n++;
      step();
    end
    check_eq("mid_bits", 32'(cnt), 32'd2);
    check_eq("mid_pending", 32'(sv1), 32'd1);
    reset = 1'b1;
    step();
    check_eq("mid_valid_clr", 32'(sv1), 32'd0);
    check_eq("mid_lfsr_reset", 32'(lr1), 32'd1);
    reset = 1'b0; sr1 = 1'b1;
    n = 0;
    while (lr1 && n < 50) begin n++; step(); end
    check_eq("refill_len", 32'(n), 32'd8);
    n = 0;
    while (!sv1 && n < 60) begin n++; step(); end
    check_eq("restart_word", 32'(sd1), 32'hF);

    // Randomized backpressure and run gating.
    for (int c = 0; c < 400; c++) begin
      sr1  = ($urandom_range(0, 3) != 0);
      run3 = ($urandom_range(0, 4) != 0);
      sr3  = ($urandom_range(0, 2) != 0);
      step();
    end
    sr1 = 1'b1; run3 = 1'b1; sr3 = 1'b1;
    for (int c = 0; c < 10; c++) step();

    // Lock-up with the LFSR forced to zero.
    mon1_en = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    n = 0;
    while (!running1 && n < 60) begin n++; step(); end
    check_eq("lock_run_timeout", 32'(n < 60), 32'd1);
    force1 = 1'b1;
`ifdef LFSR_SAMPLER_LOCKUP_DETECT_EN
    step();
    check_eq("lock_pulse", 32'(lockup1), 32'd1);
    check_eq("lock_running", 32'(running1), 32'd0);
    check_eq("lock_lfsr_reset", 32'(lr1), 32'd1);
    force1 = 1'b0;
    n = 0;
    while (lr1 && n < 50) begin
      if (n == 1) check_eq("lock_pulse_end", 32'(lockup1), 32'd0);
      n++;
      step();
    end
    check_eq("lock_refill", 32'(n), 32'd8);
`else
    any = 0; nw = 0;
    for (int c = 0; c < 40; c++) begin
      if (lockup1) any = 1;
      if (sv1) begin
        check_eq("locked_word", 32'(sd1), 32'd0);
        nw++;
      end
      step();
    end
    check_eq("lockup_tied", 32'(any), 32'd0);
    check_eq("locked_words", 32'(nw >= 2), 32'd1);
    force1 = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
